// File: rtl/lightbike_pkg.sv
// Shared definitions for the lightbike trail-grid blocks.
//   GRID_SIZE / LOG_GRID_SIZE : grid edge in cells and bits per coordinate
//   ADDR_W                    : grid RAM address width, {y,x}
//   sched_state_t             : one-hot scheduler state encoding
//   rd_tag_t                  : owner of an in-flight RAM read
package lightbike_pkg;

   localparam int GRID_SIZE     = 32;
   localparam int LOG_GRID_SIZE = 5;
   localparam int ADDR_W        = 2 * LOG_GRID_SIZE;

   typedef enum logic [6:0] {
      ST_IDLE  = 7'b000_0001,
      ST_CLEAR = 7'b000_0010,
      ST_RD_P1 = 7'b000_0100,
      ST_RD_P2 = 7'b000_1000,
      ST_WR_P1 = 7'b001_0000,
      ST_WR_P2 = 7'b010_0000,
      ST_FIN   = 7'b100_0000
   } sched_state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_VGA  = 2'd1,
      TAG_P1   = 2'd2,
      TAG_P2   = 2'd3
   } rd_tag_t;

endpackage

// File: rtl/grid_access_scheduler.sv
// Owns the single-port trail-grid RAM and shares it between the VGA renderer
// (reads, strict priority) and the game engine (clear, head reads, marks).
// A tick is sequenced atomically: read p1 cell, read p2 cell, mark both, done.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   vga_req/vga_x/vga_y        : renderer read request (granted every cycle)
//   vga_valid/vga_data         : read response, one cycle after vga_req
//   clear_req, tick            : start a grid clear / a movement tick
//   p1_x/p1_y/p2_x/p2_y        : new head positions, sampled on tick
//   busy, done                 : operation in progress / one-cycle completion
//   p1_hit, p2_hit, head_on    : collision results, valid with done, held
//   mem_addr/mem_we/mem_wdata  : grid RAM command ({y,x} address)
//   mem_rdata                  : grid RAM read data, one-cycle latency
module grid_access_scheduler #(
   parameter int GRID_SIZE     = lightbike_pkg::GRID_SIZE,
   parameter int LOG_GRID_SIZE = lightbike_pkg::LOG_GRID_SIZE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       vga_req,
   input  logic [LOG_GRID_SIZE-1:0]   vga_x,
   input  logic [LOG_GRID_SIZE-1:0]   vga_y,
   output logic                       vga_valid,
   output logic                       vga_data,
   input  logic                       clear_req,
   input  logic                       tick,
   input  logic [LOG_GRID_SIZE-1:0]   p1_x,
   input  logic [LOG_GRID_SIZE-1:0]   p1_y,
   input  logic [LOG_GRID_SIZE-1:0]   p2_x,
   input  logic [LOG_GRID_SIZE-1:0]   p2_y,
   output logic                       busy,
   output logic                       done,
   output logic                       p1_hit,
   output logic                       p2_hit,
   output logic                       head_on,
   output logic [2*LOG_GRID_SIZE-1:0] mem_addr,
   output logic                       mem_we,
   output logic                       mem_wdata,
   input  logic                       mem_rdata
);
   import lightbike_pkg::*;

   localparam int AW = 2 * LOG_GRID_SIZE;
   localparam logic [LOG_GRID_SIZE-1:0] EDGE_MAX = LOG_GRID_SIZE'(GRID_SIZE - 1);
   localparam logic [AW-1:0]            LAST_ADDR = AW'(GRID_SIZE * GRID_SIZE - 1);

   sched_state_t state, state_nxt;
   rd_tag_t      rd_tag, tag_nxt;

   logic [AW-1:0]            clr_cnt;
   logic [AW-1:0]            p1_addr, p2_addr;
   logic [LOG_GRID_SIZE-1:0] clr_x, clr_y;
   logic                     clr_border;
   logic                     game_grant;

   assign clr_x      = clr_cnt[LOG_GRID_SIZE-1:0];
   assign clr_y      = clr_cnt[AW-1:LOG_GRID_SIZE];
   assign clr_border = (clr_x == '0) || (clr_x == EDGE_MAX) ||
                       (clr_y == '0) || (clr_y == EDGE_MAX);
   assign game_grant = !vga_req;

   // Responses are steered by who issued the read, so a VGA read that lands
   // right after the last game read cannot steal or lose the game's data.
   assign vga_valid = (rd_tag == TAG_VGA);
   assign vga_data  = vga_valid & mem_rdata;

   always_comb begin
      state_nxt = state;
      tag_nxt   = TAG_NONE;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      if (vga_req) begin
         mem_addr = {vga_y, vga_x};
         tag_nxt  = TAG_VGA;
      end

      // RAM-touching states stall whole while VGA owns the port;
      // IDLE and FIN never touch the RAM so they never stall.
      unique case (state)
         ST_IDLE: begin
            if (clear_req)  state_nxt = ST_CLEAR;
            else if (tick)  state_nxt = ST_RD_P1;
         end
         ST_CLEAR: begin
            busy = 1'b1;
            if (game_grant) begin
               mem_addr  = clr_cnt;
               mem_we    = 1'b1;
               mem_wdata = clr_border;
               if (clr_cnt == LAST_ADDR) state_nxt = ST_FIN;
            end
         end
         ST_RD_P1: begin
            busy = 1'b1;
            if (game_grant) begin
               mem_addr  = p1_addr;
               tag_nxt   = TAG_P1;
               state_nxt = ST_RD_P2;
            end
         end
         ST_RD_P2: begin
            busy = 1'b1;
            if (game_grant) begin
               mem_addr  = p2_addr;
               tag_nxt   = TAG_P2;
               state_nxt = ST_WR_P1;
            end
         end
         ST_WR_P1: begin
            busy = 1'b1;
            if (game_grant) begin
               mem_addr  = p1_addr;
               mem_we    = 1'b1;
               mem_wdata = 1'b1;
               state_nxt = ST_WR_P2;
            end
         end
         ST_WR_P2: begin
            busy = 1'b1;
            if (game_grant) begin
               mem_addr  = p2_addr;
               mem_we    = 1'b1;
               mem_wdata = 1'b1;
               state_nxt = ST_FIN;
            end
         end
         ST_FIN: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // An abort must not leave a half-issued write behind.
      if (reset) begin
         mem_we    = 1'b0;
         mem_wdata = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         rd_tag  <= TAG_NONE;
         clr_cnt <= '0;
         p1_addr <= '0;
         p2_addr <= '0;
         p1_hit  <= 1'b0;
         p2_hit  <= 1'b0;
         head_on <= 1'b0;
      end else begin
         state  <= state_nxt;
         rd_tag <= tag_nxt;

         if (state == ST_IDLE) begin
            if (clear_req) begin
               clr_cnt <= '0;
               p1_hit  <= 1'b0;
               p2_hit  <= 1'b0;
               head_on <= 1'b0;
            end else if (tick) begin
               p1_addr <= {p1_y, p1_x};
               p2_addr <= {p2_y, p2_x};
               head_on <= ({p1_y, p1_x} == {p2_y, p2_x});
               p1_hit  <= 1'b0;
               p2_hit  <= 1'b0;
            end
         end

         if (state == ST_CLEAR && game_grant) clr_cnt <= clr_cnt + 1'b1;

         // A head-on is a collision for both riders regardless of the cell.
         if (rd_tag == TAG_P1) p1_hit <= mem_rdata | head_on;
         if (rd_tag == TAG_P2) p2_hit <= mem_rdata | head_on;
      end
   end

endmodule

// File: tb/tb_grid_access_scheduler.sv
// Self-checking bench for grid_access_scheduler with a behavioural RAM and a
// cell-level reference model of the grid contents and collision results.
module tb_grid_access_scheduler;

   localparam int G = 32;
   localparam int L = 5;
   localparam int N = G * G;

   logic         clk = 1'b0;
   logic         reset, vga_req, clear_req, tick;
   logic [L-1:0] vga_x, vga_y, p1_x, p1_y, p2_x, p2_y;
   logic         vga_valid, vga_data, busy, done, p1_hit, p2_hit, head_on;
   logic [2*L-1:0] mem_addr;
   logic         mem_we, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   grid_access_scheduler #(.GRID_SIZE(G), .LOG_GRID_SIZE(L)) dut (
      .clk(clk), .reset(reset),
      .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
      .vga_valid(vga_valid), .vga_data(vga_data),
      .clear_req(clear_req), .tick(tick),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .busy(busy), .done(done), .p1_hit(p1_hit), .p2_hit(p2_hit), .head_on(head_on),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous 1-bit RAM, read data one cycle after the address.
   logic ram [N];
   logic rdq;
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      rdq <= ram[mem_addr];
   end
   assign mem_rdata = rdq;

   // Reference model: expected grid contents.
   bit grid [N];
   int n_chk = 0, n_fail = 0;

   bit   prev_req = 0, prev_chk = 0, in_clear = 0;
   int   prev_addr = 0, skip_a1 = -1, skip_a2 = -1;
   logic s_done, s_busy, s_p1, s_p2, s_ho;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already driven; sample at the falling edge.
   task automatic cyc();
      int a;
      @(negedge clk);
      chk("vga_valid", 32'(vga_valid), 32'(prev_req));
      if (prev_req && prev_chk) chk("vga_data", 32'(vga_data), 32'(grid[prev_addr]));
      if (vga_req) begin
         chk("vga_grant_addr", 32'(mem_addr), 32'({vga_y, vga_x}));
         chk("vga_grant_we", 32'(mem_we), 32'd0);
      end
      s_done = done; s_busy = busy; s_p1 = p1_hit; s_p2 = p2_hit; s_ho = head_on;
      a         = int'({vga_y, vga_x});
      prev_req  = vga_req;
      prev_addr = a;
      prev_chk  = !in_clear && (a != skip_a1) && (a != skip_a2);
      @(posedge clk);
      #1;
   endtask

   task automatic set_vga(input bit r);
      vga_req = r;
      vga_x   = L'($urandom);
      vga_y   = L'($urandom);
   endtask

   function automatic bit border(input int a);
      int x, y;
      x = a % G;
      y = a / G;
      return (x == 0) || (x == G - 1) || (y == 0) || (y == G - 1);
   endfunction

   task automatic vga_read(input int a, input logic exp);
      vga_req = 1'b1;
      vga_x   = L'(a % G);
      vga_y   = L'(a / G);
      cyc();
      vga_req = 1'b0;
      chk("dump_valid", 32'(vga_valid), 32'd1);
      chk("dump_data", 32'(vga_data), 32'(exp));
      cyc();
   endtask

   // Clear; optionally with a simultaneous tick that must be dropped.
   task automatic run_clear(input bit with_tick);
      int t;
      clear_req = 1'b1;
      tick      = with_tick;
      p1_x = 5'd3; p1_y = 5'd3; p2_x = 5'd3; p2_y = 5'd3;
      cyc();
      clear_req = 1'b0;
      tick      = 1'b0;
      in_clear  = 1;
      for (t = 1; t <= 1100; t++) begin
         cyc();
         if (s_done) break;
         if (t == 1) chk("clear_busy", 32'(s_busy), 32'd1);
      end
      chk("clear_done_cycle", 32'(t), 32'(N + 1));
      chk("clear_p1_hit", 32'(s_p1), 32'd0);
      chk("clear_p2_hit", 32'(s_p2), 32'd0);
      chk("clear_head_on", 32'(s_ho), 32'd0);
      for (int i = 0; i < N; i++) grid[i] = border(i);
      in_clear = 0;
   endtask

   // mode 0: no VGA; 1: VGA held for cycles 1..20; 2: random VGA traffic.
   task automatic run_tick(input logic [L-1:0] ax, ay, bx, by, input int mode);
      int  t, frees, exp_done, a1, a2;
      bit  e1, e2, eh;
      a1 = int'({ay, ax});
      a2 = int'({by, bx});
      eh = (a1 == a2);
      e1 = grid[a1] | eh;
      e2 = grid[a2] | eh;
      skip_a1 = a1;
      skip_a2 = a2;
      frees = 0;
      exp_done = -1;
      p1_x = ax; p1_y = ay; p2_x = bx; p2_y = by;
      tick = 1'b1;
      set_vga(0);
      cyc();
      tick = 1'b0;
      p1_x = L'($urandom); p2_y = L'($urandom);
      for (t = 1; t <= 300; t++) begin
         case (mode)
            1:       set_vga(t <= 20);
            2:       set_vga(($urandom % 3) == 0);
            default: set_vga(0);
         endcase
         // Each of the four RAM steps needs one cycle the renderer leaves free.
         if (!vga_req && frees < 4) begin
            frees++;
            if (frees == 4) exp_done = t + 1;
         end
         cyc();
         if (s_done) break;
         chk("tick_busy", 32'(s_busy), 32'd1);
      end
      chk("tick_done_cycle", 32'(t), 32'(exp_done));
      chk("fin_busy", 32'(s_busy), 32'd0);
      chk("p1_hit", 32'(s_p1), 32'(e1));
      chk("p2_hit", 32'(s_p2), 32'(e2));
      chk("head_on", 32'(s_ho), 32'(eh));
      grid[a1] = 1;
      grid[a2] = 1;
      set_vga(0);
      cyc();
      skip_a1 = -1;
      skip_a2 = -1;
      chk("p1_hit_held", 32'(s_p1), 32'(e1));
      chk("done_pulse", 32'(s_done), 32'd0);
   endtask

   initial begin
      reset = 1'b1; clear_req = 1'b0; tick = 1'b0;
      vga_req = 1'b0; vga_x = '0; vga_y = '0;
      p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
      cyc();
      cyc();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vga_valid", 32'(vga_valid), 32'd0);
      chk("rst_hits", 32'({p1_hit, p2_hit, head_on}), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      cyc();

      run_clear(0);
      vga_read(0, 1'b1);
      vga_read(33, 1'b0);
      vga_read(1023, 1'b1);
      vga_read(32, 1'b1);
      vga_read(62, 1'b0);

      run_tick(5'd8, 5'd16, 5'd24, 5'd16, 0);
      vga_read(520, 1'b1);
      vga_read(536, 1'b1);
      run_tick(5'd8, 5'd16, 5'd24, 5'd16, 0);
      run_tick(5'd16, 5'd10, 5'd16, 5'd10, 0);
      run_tick(5'd4, 5'd7, 5'd20, 5'd21, 1);

      for (int k = 0; k < 40; k++) begin
         logic [L-1:0] ax, ay, bx, by;
         ax = L'($urandom); ay = L'($urandom);
         bx = L'($urandom); by = L'($urandom);
         if (($urandom % 6) == 0) begin bx = ax; by = ay; end
         run_tick(ax, ay, bx, by, 2);
      end

      // Abort a clear partway through, then clear and tick together.
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      in_clear  = 1;
      repeat (300) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      chk("abort_busy", 32'(s_busy), 32'd0);
      chk("abort_done", 32'(s_done), 32'd0);
      run_clear(1);
      vga_read(33, 1'b0);
      vga_read(99, 1'b0);
      run_tick(5'd3, 5'd3, 5'd0, 5'd9, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/grid_access_scheduler.md
Name: grid_access_scheduler

Overview:
- Owns the single-port trail-grid RAM and shares it between two requesters: the VGA pixel renderer (reads) and the game state machine (clear, collision reads, trail marks).
- Sequences a whole game tick as one atomic operation: read both new head cells, mark both cells, then report collision flags.
- Sits between the one-hot game FSM / hvsync pixel path and a synchronous 1-bit-wide grid RAM.

Parameters:
GRID_SIZE, 32, grid edge length in cells (power of two)
LOG_GRID_SIZE, 5, bits per coordinate; equals log2(GRID_SIZE)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vga_req  in  1  renderer requests a read this cycle
vga_x  in  LOG_GRID_SIZE  renderer cell x
vga_y  in  LOG_GRID_SIZE  renderer cell y
vga_valid  out  1  vga_data is valid (one cycle after vga_req)
vga_data  out  1  grid bit for the requested cell
clear_req  in  1  pulse: reinitialise the grid (border=1, interior=0)
tick  in  1  pulse: run one movement tick
p1_x, p1_y, p2_x, p2_y  in  LOG_GRID_SIZE each  new head positions, sampled on tick
busy  out  1  clear or tick in progress
done  out  1  one-cycle pulse when a clear or tick completes
p1_hit  out  1  p1 head landed on a set cell (valid with done, held until next tick/clear)
p2_hit  out  1  p2 head landed on a set cell (same timing)
head_on  out  1  p1 and p2 heads are equal (same timing)
mem_addr  out  2*LOG_GRID_SIZE  RAM address {y,x}
mem_we  out  1  RAM write enable
mem_wdata  out  1  RAM write data
mem_rdata  in  1  RAM read data, one-cycle latency

Behaviour:
- Reset: state IDLE; vga_valid, busy, done, p1_hit, p2_hit, head_on, mem_we, mem_wdata all 0; mem_addr 0.
- Arbitration: vga_req has strict priority every cycle. A granted VGA read drives mem_addr={vga_y,vga_x}, mem_we=0. Next cycle: vga_valid=1, vga_data=mem_rdata.
- The game FSM advances only in cycles without vga_req. A stalled step holds its address and data and retries. Forward progress relies on blanking intervals.
- Read-tag register: each issued read records its owner (VGA / P1 / P2). The returning mem_rdata is routed by tag, never by the current state.
- States: IDLE, CLEAR, RD_P1, RD_P2, WR_P1, WR_P2, FIN.
- IDLE:
  - clear_req -> CLEAR with addr counter 0.
  - else tick -> RD_P1, latching all four coordinates.
  - clear_req and tick in the same cycle: clear wins, tick is dropped.
  - tick or clear_req while busy: ignored.
- CLEAR: writes every address 0..GRID_SIZE^2-1 in ascending order, one per granted cycle. mem_wdata=1 if x==0, x==GRID_SIZE-1, y==0 or y==GRID_SIZE-1; else 0. After the last address -> FIN. Hit flags are cleared on entry.
- RD_P1 / RD_P2: read the latched head cell. The captured bit sets p1_hit / p2_hit.
- WR_P1 / WR_P2: write 1 to the latched head cell.
- head_on = (p1 == p2) latched at tick. If head_on, both p1_hit and p2_hit are 1.
- FIN: done=1 for one cycle, busy=0, -> IDLE. busy=1 in every other non-IDLE state.
- Uncontended latency:
  - tick sampled at cycle 0 -> done at cycle 5.
  - clear_req at cycle 0 -> done at cycle GRID_SIZE^2+1.
- The last game read's data must be captured before FIN even if VGA takes the following cycle.
- Reset mid-operation: abort immediately to IDLE; RAM contents are undefined until the next clear.
- Coordinates are always in range by width; no wrap logic is needed.

Decomposition:
- Shared package lightbike_pkg: GRID_SIZE, LOG_GRID_SIZE, address width, scheduler state encoding (one-hot, matching the game FSM style), read-tag encoding.
- No sub-module: the clear counter, arbiter and FSM stay in one module.

Test Plan:
- reset, clear_req with no vga_req -> busy for 1024 cycles, done at cycle 1025; a RAM dump shows addr 0 and 33 = 1/0 pattern correct (addr 0=1, addr 33 (x1,y1)=0, addr 1023=1).
- After clear, tick with p1=(8,16), p2=(24,16) -> done at cycle 5, p1_hit=0, p2_hit=0, head_on=0; then cells 520 and 536 read as 1.
- Repeat the same tick -> p1_hit=1, p2_hit=1, head_on=0.
- tick with p1=p2=(16,10) -> head_on=1, p1_hit=1, p2_hit=1.
- Hold vga_req high for 20 cycles during a tick -> no game RAM access during those cycles; vga_valid follows each request by exactly 1 cycle with correct data; done arrives at cycle 25.
- Assert reset during CLEAR at counter 300 -> next cycle busy=0, done=0, state IDLE; tick and clear_req in the same cycle afterward -> CLEAR is entered and the tick is dropped.
